// File: rtl/mole_spawner.sv
// mole_spawner: pseudo-random go requests at a fixed cadence, capped
// by how many moles are busy, plus the game countdown.
module mole_spawner #(
  parameter int unsigned SPAWN_INTERVAL = 25_000_000,
  parameter int unsigned SEC_CYCLES     = 50_000_000,
  parameter int unsigned GAME_SECONDS   = 60,
  parameter int unsigned MAX_ACTIVE     = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [39:0] mole_heights,
  output logic [7:0]  control,
  output logic        game_active,
  output logic [7:0]  time_left,
  output logic [7:0]  spawns
);

  localparam int IW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [IW-1:0] INT_LAST = IW'(SPAWN_INTERVAL - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_CYCLES - 1);
  localparam logic [3:0]    CAP      = 4'(MAX_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_nx;
  logic [IW-1:0] int_q, int_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [7:0]    time_q, time_d;
  logic [7:0]    spawns_q, spawns_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    tries_q, tries_d;

  logic [7:0] up, busy;
  logic [3:0] n_busy;
  logic       run, int_wrap, sec_wrap, game_end;

  // Galois form, taps x^16+x^14+x^13+x^11
  assign lfsr_nx = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    up     = '0;
    n_busy = '0;
    for (int i = 0; i < 8; i++) begin
      up[i] = |mole_heights[39-5*i -: 5];
    end
    busy = up | ctrl_q;
    for (int i = 0; i < 8; i++) begin
      n_busy = n_busy + {3'd0, busy[i]};
    end
  end

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    sec_d    = sec_q;
    time_d   = time_q;
    spawns_d = spawns_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    ctrl_d   = ctrl_q & ~up;
    run      = (state_q == S_PLAY) || (state_q == S_SEARCH);
    int_wrap = (int_q == INT_LAST);
    sec_wrap = (sec_q == SEC_LAST);
    game_end = run && sec_wrap && (time_q <= 8'd1);

    if (run) begin
      int_d = int_wrap ? '0 : int_q + 1'b1;
      sec_d = sec_wrap ? '0 : sec_q + 1'b1;
      if (sec_wrap && time_q != 8'd0) begin
        time_d = time_q - 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        ctrl_d = '0;
        time_d = '0;
        if (start) begin
          state_d  = S_PLAY;
          time_d   = 8'(GAME_SECONDS);
          spawns_d = '0;
          int_d    = '0;
          sec_d    = '0;
        end
      end
      S_PLAY: begin
        if (int_wrap && n_busy < CAP) begin
          idx_d   = lfsr_q[2:0];
          tries_d = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!busy[idx_q]) begin
          ctrl_d[idx_q] = 1'b1;
          if (spawns_q != 8'hFF) begin
            spawns_d = spawns_q + 8'd1;
          end
          state_d = S_PLAY;
        end else begin
          idx_d   = idx_q + 3'd1;
          tries_d = tries_q + 3'd1;
          if (tries_q == 3'd7) begin
            state_d = S_PLAY;
          end
        end
      end
    endcase

    // the final second wins over any spawn landing on the same edge
    if (game_end) begin
      state_d  = S_DONE;
      ctrl_d   = '0;
      spawns_d = spawns_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      int_q    <= '0;
      sec_q    <= '0;
      time_q   <= '0;
      spawns_q <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      tries_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_nx;
      int_q    <= int_d;
      sec_q    <= sec_d;
      time_q   <= time_d;
      spawns_q <= spawns_d;
      ctrl_q   <= ctrl_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
    end
  end

  assign control     = ctrl_q;
  assign game_active = run;
  assign time_left   = time_q;
  assign spawns      = spawns_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: scoreboarded go requests, a table of
// busy patterns around the search start, and countdown/reset sequences.
module tb_mole_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [39:0] h_a = '0, h_b = '0, h_c = '0;
  logic [7:0]  ctl_a, ctl_b, ctl_c;
  logic [7:0]  tl_a, tl_b, tl_c;
  logic [7:0]  sp_a, sp_b, sp_c;
  logic        ga_a, ga_b, ga_c;

  mole_spawner #(
    .SPAWN_INTERVAL(16), .SEC_CYCLES(100), .GAME_SECONDS(250),
    .MAX_ACTIVE(3), .LFSR_SEED(SEED)
  ) u_a (
    .clock(clk), .reset(rst_a), .start(start_a), .mole_heights(h_a),
    .control(ctl_a), .game_active(ga_a), .time_left(tl_a), .spawns(sp_a)
  );

  mole_spawner #(
    .SPAWN_INTERVAL(16), .SEC_CYCLES(100), .GAME_SECONDS(250),
    .MAX_ACTIVE(8), .LFSR_SEED(SEED)
  ) u_b (
    .clock(clk), .reset(rst_b), .start(start_b), .mole_heights(h_b),
    .control(ctl_b), .game_active(ga_b), .time_left(tl_b), .spawns(sp_b)
  );

  mole_spawner #(
    .SPAWN_INTERVAL(16), .SEC_CYCLES(32), .GAME_SECONDS(2),
    .MAX_ACTIVE(3), .LFSR_SEED(SEED)
  ) u_c (
    .clock(clk), .reset(rst_c), .start(start_c), .mole_heights(h_c),
    .control(ctl_c), .game_active(ga_c), .time_left(tl_c), .spawns(sp_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] oh(int i);
    logic [7:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int first_free(int idx, logic [7:0] busy);
    for (int j = 0; j < 8; j++) begin
      if (!busy[(idx + j) % 8]) return (idx + j) % 8;
    end
    return 8;
  endfunction

  function automatic logic [39:0] put(logic [39:0] h, int i, logic [4:0] v);
    logic [39:0] r;
    r = h;
    r[39-5*i -: 5] = v;
    return r;
  endfunction

  function automatic logic [39:0] hmask(logic [7:0] m, logic [4:0] v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[39-5*i -: 5] = v;
    end
    return r;
  endfunction

  // reference LFSRs, stepped on the same edges as the designs
  logic [15:0] la, lb;
  always @(posedge clk or posedge rst_a)
    if (rst_a) la <= SEED;
    else       la <= lfsr_step(la);
  always @(posedge clk or posedge rst_b)
    if (rst_b) lb <= SEED;
    else       lb <= lfsr_step(lb);

  // scoreboard for instance a
  logic [7:0] q_a[$];
  logic [7:0] prev_a = '0;
  always @(negedge clk) begin : mon_a
    logic [7:0] nw;
    nw = ctl_a & ~prev_a;
    prev_a = ctl_a;
    if (nw != 8'h00) begin
      if (q_a.size() == 0) chk("sb_unexpected_go", {24'd0, nw}, 32'd0);
      else                 chk("sb_go", {24'd0, nw}, {24'd0, q_a.pop_front()});
    end
  end

  int         a_cyc = 0, b_cyc = 0, c_cyc = 0;
  bit         a_run = 1'b0;
  logic [7:0] a_busy = '0;

  task automatic step_a();
    int p;
    if (a_run && ((a_cyc + 1) % 16 == 0) && $countones(a_busy) < 3) begin
      p = first_free(int'(la[2:0]), a_busy);
      if (p < 8) begin
        q_a.push_back(oh(p));
        a_busy[p] = 1'b1;
      end
    end
    @(posedge clk);
    a_cyc++;
    @(negedge clk);
  endtask

  task automatic step_b();
    @(posedge clk);
    b_cyc++;
    @(negedge clk);
  endtask

  task automatic step_c();
    @(posedge clk);
    c_cyc++;
    @(negedge clk);
  endtask

  task automatic start_a_game();
    start_a = 1'b1;
    @(posedge clk);
    a_cyc = 0;
    a_run = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_b_game();
    start_b = 1'b1;
    @(posedge clk);
    b_cyc = 0;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic start_c_game();
    start_c = 1'b1;
    @(posedge clk);
    c_cyc = 0;
    @(negedge clk);
    start_c = 1'b0;
  endtask

  typedef struct {
    logic [7:0] rel_up;
    int         off;
  } vec_t;

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: run did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    vec_t       vt[8];
    logic [7:0] acc8;
    logic [7:0] exp8;
    int         k, idx;

    // rel_up bit r: mole (idx+r)%8 is up; off: first free offset, 8 = none
    vt[0] = '{8'h00, 0};
    vt[1] = '{8'h01, 1};
    vt[2] = '{8'h03, 2};
    vt[3] = '{8'h7F, 7};
    vt[4] = '{8'hFE, 0};
    vt[5] = '{8'hBF, 6};
    vt[6] = '{8'hFF, 8};
    vt[7] = '{8'h55, 1};

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {24'd0, ctl_a}, 0);
    chk("rst_active", {31'd0, ga_a}, 0);
    chk("rst_time", {24'd0, tl_a}, 0);
    chk("rst_spawns", {24'd0, sp_a}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    acc8 = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc8 = acc8 | ctl_a | tl_a | sp_a | {7'd0, ga_a};
    end
    chk("idle_100_quiet", {24'd0, acc8}, 0);

    // first go, handshake hold and release, no re-issue to an up mole
    a_busy = '0;
    start_a_game();
    chk("a_time_load", {24'd0, tl_a}, 250);
    chk("a_active", {31'd0, ga_a}, 1);
    chk("a_spawns_clear", {24'd0, sp_a}, 0);
    while (a_cyc < 15) step_a();
    k = int'(la[2:0]);
    step_a();
    chk("a_no_go_at_wrap", {24'd0, ctl_a}, 0);
    step_a();
    chk("a_first_go", {24'd0, ctl_a}, {24'd0, oh(k)});
    chk("a_spawns_1", {24'd0, sp_a}, 1);
    for (int i = 0; i < 4; i++) begin
      step_a();
      chk("a_go_held", {31'd0, ctl_a[k]}, 1);
    end
    h_a = put(h_a, k, 5'd1);
    step_a();
    chk("a_go_cleared", {31'd0, ctl_a[k]}, 0);
    acc8 = '0;
    while (a_cyc < 99) begin
      step_a();
      acc8 = acc8 | (ctl_a & oh(k));
    end
    chk("a_no_rego", {24'd0, acc8}, 0);
    chk("a_time_250", {24'd0, tl_a}, 250);
    step_a();
    chk("a_time_249", {24'd0, tl_a}, 249);
    chk("a_spawns_3", {24'd0, sp_a}, 3);
    chk("a_sb_drained", q_a.size(), 0);

    // active cap
    rst_a = 1'b1;
    a_run = 1'b0;
    @(negedge clk);
    h_a = hmask(8'b0101_0010, 5'd20);
    a_busy = 8'b0101_0010;
    rst_a = 1'b0;
    start_a_game();
    while (a_cyc < 160) step_a();
    chk("a_cap_no_go", {24'd0, sp_a}, 0);
    h_a = put(h_a, 4, 5'd0);
    a_busy[4] = 1'b0;
    while (a_cyc < 185) step_a();
    chk("a_cap_release_spawns", {24'd0, sp_a}, 1);
    chk("a_cap_one_bit", $countones(ctl_a), 1);
    chk("a_sb_drained2", q_a.size(), 0);

    // search patterns relative to the LFSR start index
    start_b_game();
    for (int v = 0; v < 8; v++) begin
      while ((b_cyc + 1) % 16 != 0) step_b();
      idx = int'(lb[2:0]);
      h_b = '0;
      for (int r = 0; r < 8; r++) begin
        if (vt[v].rel_up[r]) h_b = put(h_b, (idx + r) % 8, 5'd9);
      end
      step_b();
      for (int t = 1; t <= 9; t++) begin
        step_b();
        exp8 = (vt[v].off < 8 && t > vt[v].off) ?
               oh((idx + vt[v].off) % 8) : 8'h00;
        chk($sformatf("vec%0d_t%0d", v, t), {24'd0, ctl_b}, {24'd0, exp8});
      end
      h_b = '0;
      if (vt[v].off < 8) begin
        h_b = put(h_b, (idx + vt[v].off) % 8, 5'd1);
        step_b();
        h_b = '0;
      end
    end
    chk("b_table_spawns", {24'd0, sp_b}, 7);

    // eight misses, then the next attempt still works
    while ((b_cyc + 1) % 16 != 0) step_b();
    h_b = hmask(8'hFE, 5'd9);
    step_b();
    h_b = hmask(8'hFF, 5'd9);
    acc8 = '0;
    for (int i = 0; i < 9; i++) begin
      step_b();
      acc8 = acc8 | ctl_b;
    end
    chk("b_eight_miss_no_go", {24'd0, acc8}, 0);
    chk("b_eight_miss_spawns", {24'd0, sp_b}, 7);
    h_b = '0;
    while ((b_cyc + 1) % 16 != 0) step_b();
    idx = int'(lb[2:0]);
    step_b();
    step_b();
    chk("b_search_resumes", {24'd0, ctl_b}, {24'd0, oh(idx)});
    chk("b_spawns_8", {24'd0, sp_b}, 8);

    // countdown, game end, restart, async reset mid-search
    start_c_game();
    while (c_cyc < 31) step_c();
    chk("c_time_2", {24'd0, tl_c}, 2);
    step_c();
    chk("c_time_1", {24'd0, tl_c}, 1);
    while (c_cyc < 63) step_c();
    chk("c_time_1_late", {24'd0, tl_c}, 1);
    chk("c_three_pending", $countones(ctl_c), 3);
    step_c();
    chk("c_time_0", {24'd0, tl_c}, 0);
    chk("c_done_inactive", {31'd0, ga_c}, 0);
    chk("c_done_ctrl", {24'd0, ctl_c}, 0);
    chk("c_done_spawns", {24'd0, sp_c}, 3);
    repeat (40) step_c();
    chk("c_no_underflow", {24'd0, tl_c}, 0);
    chk("c_spawns_hold", {24'd0, sp_c}, 3);
    start_c_game();
    chk("c_reload", {24'd0, tl_c}, 2);
    chk("c_spawns_clear", {24'd0, sp_c}, 0);
    while (c_cyc < 16) step_c();
    chk("c_mid_search", {23'd0, ga_c, ctl_c}, 32'h100);
    rst_c = 1'b1;
    #1;
    chk("c_async_reset", {7'd0, ctl_c, ga_c, tl_c, sp_c}, 0);
    @(negedge clk);
    rst_c = 1'b0;
    start_c_game();
    chk("c_reload_after_reset", {24'd0, tl_c}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
